inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Streaming RV64IM instruction encoder: takes an abstract op plus operand fields over valid/ready and emits 32-bit encodings over valid/ready.
- Emits only encodings the core's decoder accepts, so its output drives directly into fetch/decode-check benches and the self-test instruction buffer.
- Expands pseudo-op LI into one or two real instructions through a small state machine.
- Flags unencodable requests instead of emitting garbage.

Parameters:
- ERR_INST, 32'h0000_0000, value driven on out_inst for a rejected request.
- SUPPORT_LI, 1, when 0 the LI op is treated as unsupported (err).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_op  in  6  op code from enc_pkg::enc_op_e
- in_rd / in_rs1 / in_rs2  in  5 each  register indices
- in_imm  in  32  signed immediate / shamt / offset (byte units)
- out_valid  out  1  encoding valid
- out_ready  in  1  consumer accepts
- out_inst  out  32  encoded instruction
- out_err  out  1  request unencodable; out_inst = ERR_INST
- out_last  out  1  final beat of the current request

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; out_valid=0, out_inst=0, out_err=0, out_last=0. in_ready=1 on the first cycle after reset.
- in_ready = (state==IDLE) && (!out_valid || out_ready), combinational.
- A request is accepted at an edge with in_valid && in_ready. The output register loads at that same edge, so out_valid=1 in the next cycle (latency 1). Back-to-back accepts give one beat per cycle.
- The output holds stable (inst/err/last) while out_valid && !out_ready.
- States:
  - IDLE: waiting for a request.
  - LI_PEND: second LI beat is pending.
  - IDLE -> LI_PEND when an LI is accepted that needs two beats.
  - LI_PEND -> IDLE at the edge where beat 1 is consumed. Beat 2 loads into the output register at that same edge, with no bubble.
  - in_ready=0 in LI_PEND.
- Supported ops, matching the decoder set:
  - R: ADD SUB MUL SLL SLT SLTU XOR SRL SRA OR AND
  - RW: ADDW SUBW MULW SLLW SRLW SRAW DIVW REMW
  - I: ADDI SLTI SLTIU XORI ORI ANDI
  - shifts: SLLI SRLI SRAI, SLLIW SRLIW SRAIW
  - ADDIW; loads LD LW LH LHU LBU; stores SB SH SW SD
  - branches BEQ BNE BLT BGE BLTU BGEU
  - JAL JALR LUI AUIPC EBREAK LI
- Range rules (violation → out_err=1, out_inst=ERR_INST, out_last=1, single beat):
  - I/load/store/JALR imm in [-2048,2047].
  - RV64 shifts shamt in [0,63]; W shifts in [0,31]. SRAI/SRAIW set funct7[5].
  - Branch imm even, in [-4096,4094]. JAL imm even, in [-2^20, 2^20-2].
  - LUI/AUIPC: imm[11:0] must be 0; imm[31:12] is the U field.
  - Undefined enum codes are an error.
- LI rd, imm (value = sign-extended imm[31:0]):
  - If imm fits 12-bit signed: single ADDI rd,x0,imm.
  - Else hi=(imm+0x800)>>12 and lo=imm-(hi<<12). Emit LUI rd,hi; then ADDIW rd,rd,lo, unless lo==0, in which case LUI only with out_last=1.
  - imm in [0x7FFFF800,0x7FFFFFFF] is an error, because hi overflows.
- Ignored fields are encoded as 0: rs2 for I-type, rd for S/B.
- EBREAK = 32'h0010_0073.
- rst in LI_PEND or with output stalled: the pending beat and held output are dropped; reset values are restored.

Decomposition:
- enc_pkg holds:
  - enc_op_e enum (6-bit)
  - opcode constants (OP_R, OP_RW, OP_IMM, OP_IMMW, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM)
  - funct3/funct7 constants
  - immediate range-limit constants
- Sub-module inst_field_pack (combinational): op + fields → {inst, err}. It contains all R/I/S/B/U/J bit packing. The top holds the handshake, LI FSM and output register.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, out_ready=1 → out_inst=0x00500093, out_err=0, out_last=1, one cycle after accept.
- BEQ rs1=1 rs2=2 imm=8 → 0x00208463. EBREAK → 0x00100073.
- LI rd=5 imm=0x12345678 → beat1 0x123452B7 (last=0), beat2 0x6782829B (last=1), in_ready=0 between beats.
- LI rd=1 imm=0x00000FFF → 0x000010B7 then 0xFFF0809B.
- LI imm=0x12345000 → single 0x123452B7 with last=1.
- ADDI imm=2048 → out_err=1, out_inst=0x00000000. BEQ imm=3 → err. LI imm=0x7FFFFFFF → err.
- Backpressure: hold out_ready=0 for 5 cycles after accept → out_inst stable, in_ready=0. Assert rst in LI_PEND → next cycle out_valid=0, in_ready=1, and beat 2 is never emitted.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared definitions for the RV64IM instruction encoder: abstract op codes,
// major opcodes, funct fields and immediate range limits.
package enc_pkg;

  typedef enum logic [5:0] {
    ADD, SUB, MUL, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    ADDW, SUBW, MULW, SLLW, SRLW, SRAW, DIVW, REMW,
    ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
    SLLI, SRLI, SRAI, SLLIW, SRLIW, SRAIW,
    ADDIW, LD, LW, LH, LHU, LBU,
    SB, SH, SW, SD,
    BEQ, BNE, BLT, BGE, BLTU, BGEU,
    JAL, JALR, LUI, AUIPC, EBREAK, LI
  } enc_op_e;

  typedef enum logic {IDLE, LI_PEND} enc_state_e;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_RW     = 7'h3B;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_IMMW   = 7'h1B;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_DIV  = 3'd4, F3_REM = 3'd6;
  localparam logic [2:0] F3_LH   = 3'd1, F3_LW  = 3'd2, F3_LD  = 3'd3, F3_LBU  = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH  = 3'd1, F3_SW  = 3'd2, F3_SD   = 3'd3;
  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam int IMM12_MIN   = -2048;
  localparam int IMM12_MAX   = 2047;
  localparam int SHAMT64_MAX = 63;
  localparam int SHAMT32_MAX = 31;
  localparam int BR_MIN      = -4096;
  localparam int BR_MAX      = 4094;
  localparam int JAL_MIN     = -1048576;
  localparam int JAL_MAX     = 1048574;

endpackage

// File: rtl/inst_field_pack.sv
// Combinational R/I/S/B/U/J packer: abstract op plus fields to a 32-bit word,
// with err raised for out-of-range immediates and unknown op codes.
module inst_field_pack
  import enc_pkg::*;
(
  input  logic        [5:0]  op,
  input  logic        [4:0]  rd,
  input  logic        [4:0]  rs1,
  input  logic        [4:0]  rs2,
  input  logic signed [31:0] imm,
  output logic        [31:0] inst,
  output logic               err
);

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] s2,
                                      input logic [4:0] s1, input logic [2:0] f3,
                                      input logic [4:0] d, input logic [6:0] opc);
    return {f7, s2, s1, f3, d, opc};
  endfunction

  function automatic logic [31:0] i_t(input logic [11:0] i12, input logic [4:0] s1,
                                      input logic [2:0] f3, input logic [4:0] d,
                                      input logic [6:0] opc);
    return {i12, s1, f3, d, opc};
  endfunction

  function automatic logic [31:0] s_t(input logic [11:0] i12, input logic [4:0] s2,
                                      input logic [4:0] s1, input logic [2:0] f3);
    return {i12[11:5], s2, s1, f3, i12[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] b_t(input logic [12:0] i13, input logic [4:0] s2,
                                      input logic [4:0] s1, input logic [2:0] f3);
    return {i13[12], i13[10:5], s2, s1, f3, i13[4:1], i13[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] j_t(input logic [20:0] i21, input logic [4:0] d);
    return {i21[20], i21[10:1], i21[11], i21[19:12], d, OP_JAL};
  endfunction

  logic fit12, fit_sh64, fit_sh32, fit_br, fit_jal, u_ok;
  logic ok;
  logic [31:0] cand;

  assign fit12    = (imm >= IMM12_MIN) && (imm <= IMM12_MAX);
  assign fit_sh64 = (imm >= 0) && (imm <= SHAMT64_MAX);
  assign fit_sh32 = (imm >= 0) && (imm <= SHAMT32_MAX);
  assign fit_br   = !imm[0] && (imm >= BR_MIN) && (imm <= BR_MAX);
  assign fit_jal  = !imm[0] && (imm >= JAL_MIN) && (imm <= JAL_MAX);
  assign u_ok     = (imm[11:0] == 12'h000);

  always_comb begin
    cand = '0;
    ok   = 1'b1;
    case (op)
      ADD:    cand = r_t(F7_BASE,   rs2, rs1, F3_ADD,  rd, OP_R);
      SUB:    cand = r_t(F7_ALT,    rs2, rs1, F3_ADD,  rd, OP_R);
      MUL:    cand = r_t(F7_MULDIV, rs2, rs1, F3_ADD,  rd, OP_R);
      SLL:    cand = r_t(F7_BASE,   rs2, rs1, F3_SLL,  rd, OP_R);
      SLT:    cand = r_t(F7_BASE,   rs2, rs1, F3_SLT,  rd, OP_R);
      SLTU:   cand = r_t(F7_BASE,   rs2, rs1, F3_SLTU, rd, OP_R);
      XOR:    cand = r_t(F7_BASE,   rs2, rs1, F3_XOR,  rd, OP_R);
      SRL:    cand = r_t(F7_BASE,   rs2, rs1, F3_SR,   rd, OP_R);
      SRA:    cand = r_t(F7_ALT,    rs2, rs1, F3_SR,   rd, OP_R);
      OR:     cand = r_t(F7_BASE,   rs2, rs1, F3_OR,   rd, OP_R);
      AND:    cand = r_t(F7_BASE,   rs2, rs1, F3_AND,  rd, OP_R);
      ADDW:   cand = r_t(F7_BASE,   rs2, rs1, F3_ADD,  rd, OP_RW);
      SUBW:   cand = r_t(F7_ALT,    rs2, rs1, F3_ADD,  rd, OP_RW);
      MULW:   cand = r_t(F7_MULDIV, rs2, rs1, F3_ADD,  rd, OP_RW);
      SLLW:   cand = r_t(F7_BASE,   rs2, rs1, F3_SLL,  rd, OP_RW);
      SRLW:   cand = r_t(F7_BASE,   rs2, rs1, F3_SR,   rd, OP_RW);
      SRAW:   cand = r_t(F7_ALT,    rs2, rs1, F3_SR,   rd, OP_RW);
      DIVW:   cand = r_t(F7_MULDIV, rs2, rs1, F3_DIV,  rd, OP_RW);
      REMW:   cand = r_t(F7_MULDIV, rs2, rs1, F3_REM,  rd, OP_RW);
      ADDI:   begin cand = i_t(imm[11:0], rs1, F3_ADD,  rd, OP_IMM);  ok = fit12; end
      SLTI:   begin cand = i_t(imm[11:0], rs1, F3_SLT,  rd, OP_IMM);  ok = fit12; end
      SLTIU:  begin cand = i_t(imm[11:0], rs1, F3_SLTU, rd, OP_IMM);  ok = fit12; end
      XORI:   begin cand = i_t(imm[11:0], rs1, F3_XOR,  rd, OP_IMM);  ok = fit12; end
      ORI:    begin cand = i_t(imm[11:0], rs1, F3_OR,   rd, OP_IMM);  ok = fit12; end
      ANDI:   begin cand = i_t(imm[11:0], rs1, F3_AND,  rd, OP_IMM);  ok = fit12; end
      ADDIW:  begin cand = i_t(imm[11:0], rs1, F3_ADD,  rd, OP_IMMW); ok = fit12; end
      // RV64 shifts carry a 6-bit shamt; funct7[5] of SRAI lands on imm[10]
      SLLI:   begin cand = i_t({6'b000000, imm[5:0]}, rs1, F3_SLL, rd, OP_IMM);  ok = fit_sh64; end
      SRLI:   begin cand = i_t({6'b000000, imm[5:0]}, rs1, F3_SR,  rd, OP_IMM);  ok = fit_sh64; end
      SRAI:   begin cand = i_t({6'b010000, imm[5:0]}, rs1, F3_SR,  rd, OP_IMM);  ok = fit_sh64; end
      SLLIW:  begin cand = i_t({F7_BASE, imm[4:0]},   rs1, F3_SLL, rd, OP_IMMW); ok = fit_sh32; end
      SRLIW:  begin cand = i_t({F7_BASE, imm[4:0]},   rs1, F3_SR,  rd, OP_IMMW); ok = fit_sh32; end
      SRAIW:  begin cand = i_t({F7_ALT,  imm[4:0]},   rs1, F3_SR,  rd, OP_IMMW); ok = fit_sh32; end
      LD:     begin cand = i_t(imm[11:0], rs1, F3_LD,  rd, OP_LOAD); ok = fit12; end
      LW:     begin cand = i_t(imm[11:0], rs1, F3_LW,  rd, OP_LOAD); ok = fit12; end
      LH:     begin cand = i_t(imm[11:0], rs1, F3_LH,  rd, OP_LOAD); ok = fit12; end
      LHU:    begin cand = i_t(imm[11:0], rs1, F3_LHU, rd, OP_LOAD); ok = fit12; end
      LBU:    begin cand = i_t(imm[11:0], rs1, F3_LBU, rd, OP_LOAD); ok = fit12; end
      JALR:   begin cand = i_t(imm[11:0], rs1, F3_ADD, rd, OP_JALR); ok = fit12; end
      SB:     begin cand = s_t(imm[11:0], rs2, rs1, F3_SB); ok = fit12; end
      SH:     begin cand = s_t(imm[11:0], rs2, rs1, F3_SH); ok = fit12; end
      SW:     begin cand = s_t(imm[11:0], rs2, rs1, F3_SW); ok = fit12; end
      SD:     begin cand = s_t(imm[11:0], rs2, rs1, F3_SD); ok = fit12; end
      BEQ:    begin cand = b_t(imm[12:0], rs2, rs1, F3_BEQ);  ok = fit_br; end
      BNE:    begin cand = b_t(imm[12:0], rs2, rs1, F3_BNE);  ok = fit_br; end
      BLT:    begin cand = b_t(imm[12:0], rs2, rs1, F3_BLT);  ok = fit_br; end
      BGE:    begin cand = b_t(imm[12:0], rs2, rs1, F3_BGE);  ok = fit_br; end
      BLTU:   begin cand = b_t(imm[12:0], rs2, rs1, F3_BLTU); ok = fit_br; end
      BGEU:   begin cand = b_t(imm[12:0], rs2, rs1, F3_BGEU); ok = fit_br; end
      JAL:    begin cand = j_t(imm[20:0], rd); ok = fit_jal; end
      LUI:    begin cand = {imm[31:12], rd, OP_LUI};   ok = u_ok; end
      AUIPC:  begin cand = {imm[31:12], rd, OP_AUIPC}; ok = u_ok; end
      EBREAK: cand = INST_EBREAK;
      default: ok = 1'b0;
    endcase
    inst = ok ? cand : '0;
    err  = !ok;
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV64IM encoder: valid/ready request in, one or two 32-bit beats out,
// with the LI pseudo-op split into LUI+ADDIW when it does not fit 12 bits.
module inst_encoder
  import enc_pkg::*;
#(
  parameter logic [31:0] ERR_INST   = 32'h0000_0000,
  parameter bit          SUPPORT_LI = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic        [5:0]  in_op,
  input  logic        [4:0]  in_rd,
  input  logic        [4:0]  in_rs1,
  input  logic        [4:0]  in_rs2,
  input  logic signed [31:0] in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic        [31:0] out_inst,
  output logic               out_err,
  output logic               out_last
);

  enc_state_e state;
  logic               vld_p1, err_p1, last_p1;
  logic        [31:0] inst_p1;
  logic        [31:0] pend_inst_p1;
  logic               pend_err_p1;

  logic               accept, is_li, li_fit12, li_ovf, li_two;
  logic signed [32:0] li_sum;
  logic        [5:0]  b1_op;
  logic        [4:0]  b1_rs1;
  logic signed [31:0] b1_imm, b2_imm;
  logic        [31:0] b1_inst, b2_inst;
  logic               b1_err, b2_err, b1_bad;

  assign in_ready = (state == IDLE) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;

  // LI split: hi rounds so that lo is the sign-extended low 12 bits
  assign is_li    = (in_op == LI) && SUPPORT_LI;
  assign li_sum   = {in_imm[31], in_imm} + 33'sd2048;
  assign li_ovf   = li_sum[32] ^ li_sum[31];
  assign li_fit12 = (in_imm >= IMM12_MIN) && (in_imm <= IMM12_MAX);
  assign li_two   = is_li && !li_fit12 && !li_ovf && (in_imm[11:0] != 12'h000);
  assign b2_imm   = {{20{in_imm[11]}}, in_imm[11:0]};

  always_comb begin
    b1_op  = in_op;
    b1_rs1 = in_rs1;
    b1_imm = in_imm;
    if (is_li) begin
      if (li_fit12) begin
        b1_op  = ADDI;
        b1_rs1 = '0;
      end else begin
        b1_op  = LUI;
        b1_imm = {li_sum[31:12], 12'h000};
      end
    end
  end

  assign b1_bad = b1_err || (is_li && !li_fit12 && li_ovf);

  inst_field_pack u_pack_b1 (
    .op   (b1_op),
    .rd   (in_rd),
    .rs1  (b1_rs1),
    .rs2  (in_rs2),
    .imm  (b1_imm),
    .inst (b1_inst),
    .err  (b1_err)
  );

  inst_field_pack u_pack_b2 (
    .op   (ADDIW),
    .rd   (in_rd),
    .rs1  (in_rd),
    .rs2  (5'd0),
    .imm  (b2_imm),
    .inst (b2_inst),
    .err  (b2_err)
  );

  // p1: output register and LI state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      err_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            vld_p1  <= 1'b1;
            inst_p1 <= b1_bad ? ERR_INST : b1_inst;
            err_p1  <= b1_bad;
            last_p1 <= !li_two;
            if (li_two) state <= LI_PEND;
          end else if (out_ready) begin
            vld_p1 <= 1'b0;
          end
        end
        LI_PEND: begin
          if (out_ready) begin
            inst_p1 <= pend_err_p1 ? ERR_INST : pend_inst_p1;
            err_p1  <= pend_err_p1;
            last_p1 <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pend_inst_p1 <= b2_inst;
      pend_err_p1  <= b2_err;
    end
  end

  assign out_valid = vld_p1;
  assign out_inst  = inst_p1;
  assign out_err   = err_p1;
  assign out_last  = last_p1;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, range errors, LI expansion,
// back-to-back accepts, backpressure and reset during a pending LI beat.
module tb_inst_encoder;
  import enc_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic        [5:0]  in_op;
  logic        [4:0]  in_rd, in_rs1, in_rs2;
  logic signed [31:0] in_imm;
  logic               out_valid;
  logic               out_ready;
  logic        [31:0] out_inst;
  logic               out_err;
  logic               out_last;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Drives one request and returns #1 after the accepting edge.
  task automatic do_req(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
    int t;
    t = 0;
    @(negedge clk);
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, t);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %08h want 00000000", out_inst); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", out_err); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %0b want 0", out_last); end
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_encodings;
    vec_t v[13];
    v[0]  = '{ADDI,   5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093};
    v[1]  = '{BEQ,    5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463};
    v[2]  = '{EBREAK, 5'd0, 5'd0, 5'd0, 32'd0,          32'h00100073};
    v[3]  = '{ADD,    5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3};
    v[4]  = '{SUB,    5'd3, 5'd1, 5'd2, 32'd0,          32'h402081B3};
    v[5]  = '{SRAI,   5'd1, 5'd2, 5'd0, 32'd63,         32'h43F15093};
    v[6]  = '{SD,     5'd7, 5'd1, 5'd2, 32'd8,          32'h0020B423};
    v[7]  = '{JAL,    5'd0, 5'd0, 5'd0, 32'd8,          32'h0080006F};
    v[8]  = '{LUI,    5'd1, 5'd0, 5'd0, 32'h12345000,   32'h123450B7};
    v[9]  = '{MULW,   5'd3, 5'd1, 5'd2, 32'd0,          32'h022081BB};
    v[10] = '{LD,     5'd1, 5'd2, 5'd0, 32'hFFFFFFF8,   32'hFF813083};
    v[11] = '{BNE,    5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE209EE3};
    v[12] = '{SLLIW,  5'd1, 5'd2, 5'd0, 32'd31,         32'h01F1109B};
    for (int i = 0; i < 13; i++) begin
      do_req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      n_checks++; if (out_inst !== v[i].exp) begin n_fail++; $display("FAIL enc_inst[%0d]: got %08h want %08h", i, out_inst, v[i].exp); end
      n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b0 || out_last !== 1'b1) begin
        n_fail++; $display("FAIL enc_flags[%0d]: valid/err/last got %0b%0b%0b want 101", i, out_valid, out_err, out_last);
      end
    end
  endtask

  task automatic test_errors;
    vec_t v[9];
    v[0] = '{ADDI,   5'd1, 5'd0, 5'd0, 32'd2048,       32'h0};
    v[1] = '{BEQ,    5'd0, 5'd1, 5'd2, 32'd3,          32'h0};
    v[2] = '{LI,     5'd1, 5'd0, 5'd0, 32'h7FFFFFFF,   32'h0};
    v[3] = '{6'd63,  5'd1, 5'd1, 5'd1, 32'd0,          32'h0};
    v[4] = '{SLLIW,  5'd1, 5'd2, 5'd0, 32'd32,         32'h0};
    v[5] = '{LUI,    5'd1, 5'd0, 5'd0, 32'h00000123,   32'h0};
    v[6] = '{JAL,    5'd1, 5'd0, 5'd0, 32'd1048576,    32'h0};
    v[7] = '{SRAI,   5'd1, 5'd2, 5'd0, 32'hFFFFFFFF,   32'h0};
    v[8] = '{SD,     5'd0, 5'd1, 5'd2, 32'hFFFFF7FF,   32'h0};
    for (int i = 0; i < 9; i++) begin
      do_req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      n_checks++; if (out_inst !== v[i].exp) begin n_fail++; $display("FAIL err_inst[%0d]: got %08h want %08h", i, out_inst, v[i].exp); end
      n_checks++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_last !== 1'b1) begin
        n_fail++; $display("FAIL err_flags[%0d]: valid/err/last got %0b%0b%0b want 111", i, out_valid, out_err, out_last);
      end
    end
  endtask

  task automatic test_li;
    logic [31:0] imm_t [4];
    logic [4:0]  rd_t  [4];
    logic [31:0] b1_t  [4];
    logic [31:0] b2_t  [4];
    logic        two_t [4];
    imm_t[0] = 32'h12345678; rd_t[0] = 5'd5; b1_t[0] = 32'h123452B7; b2_t[0] = 32'h6782829B; two_t[0] = 1'b1;
    imm_t[1] = 32'h00000FFF; rd_t[1] = 5'd1; b1_t[1] = 32'h000010B7; b2_t[1] = 32'hFFF0809B; two_t[1] = 1'b1;
    imm_t[2] = 32'h12345000; rd_t[2] = 5'd5; b1_t[2] = 32'h123452B7; b2_t[2] = 32'h0;        two_t[2] = 1'b0;
    imm_t[3] = 32'hFFFFFFFF; rd_t[3] = 5'd1; b1_t[3] = 32'hFFF00093; b2_t[3] = 32'h0;        two_t[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      do_req(LI, rd_t[i], 5'd0, 5'd0, imm_t[i]);
      n_checks++; if (out_inst !== b1_t[i]) begin n_fail++; $display("FAIL li_beat1[%0d]: got %08h want %08h", i, out_inst, b1_t[i]); end
      n_checks++; if (out_last !== !two_t[i] || out_err !== 1'b0) begin n_fail++; $display("FAIL li_beat1_flags[%0d]: last/err got %0b%0b want %0b0", i, out_last, out_err, !two_t[i]); end
      n_checks++; if (in_ready !== !two_t[i]) begin n_fail++; $display("FAIL li_in_ready[%0d]: got %0b want %0b", i, in_ready, !two_t[i]); end
      if (two_t[i]) begin
        @(posedge clk); #1;
        n_checks++; if (out_inst !== b2_t[i]) begin n_fail++; $display("FAIL li_beat2[%0d]: got %08h want %08h", i, out_inst, b2_t[i]); end
        n_checks++; if (out_valid !== 1'b1 || out_last !== 1'b1) begin n_fail++; $display("FAIL li_beat2_flags[%0d]: valid/last got %0b%0b want 11", i, out_valid, out_last); end
      end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL li_drain[%0d]: valid got %0b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_op = ADDI; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'sd5; in_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_inst !== 32'h00500093 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got %08h v=%0b want 00500093 v=1", out_inst, out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %0b want 1", in_ready); end
    in_rd = 5'd2; in_imm = 32'sd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_inst !== 32'h00600113 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_second: got %08h v=%0b want 00600113 v=1", out_inst, out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: valid got %0b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    do_req(ADD, 5'd3, 5'd1, 5'd2, 32'd0);
    @(negedge clk);
    in_op = ADDI; in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'sd5; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++; if (out_inst !== 32'h002081B3 || out_valid !== 1'b1 || out_last !== 1'b1) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got %08h v=%0b l=%0b want 002081B3 v=1 l=1", c, out_inst, out_valid, out_last);
      end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", c, in_ready); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (out_inst !== 32'h00500093 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %08h v=%0b want 00500093 v=1", out_inst, out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle: valid got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_li_pend;
    out_ready = 1'b0;
    do_req(LI, 5'd5, 5'd0, 5'd0, 32'h12345678);
    n_checks++; if (out_inst !== 32'h123452B7 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rstp_pend: got %08h rdy=%0b want 123452B7 rdy=0", out_inst, in_ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || out_last !== 1'b0 || out_inst !== 32'h0) begin
      n_fail++; $display("FAIL rstp_out: v=%0b l=%0b inst=%08h want 0 0 00000000", out_valid, out_last, out_inst);
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstp_in_ready: got %0b want 1", in_ready); end
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstp_no_beat2[%0d]: valid got %0b inst=%08h want 0", c, out_valid, out_inst); end
    end
  endtask

  initial begin
    test_reset();
    test_encodings();
    test_errors();
    test_li();
    test_back_to_back();
    test_backpressure();
    test_reset_li_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
